// File: rtl/fb_pkg.sv
// Shared constants, beat type and clip helper for the framebuffer writer.
package fb_pkg;

    localparam int H_RES    = 800;
    localparam int V_RES    = 600;
    localparam int ADDR_W   = 20;
    localparam int ROW_W    = ADDR_W - 1;   // linear pixel offset width
    localparam int BANK_BIT = ADDR_W - 1;   // address MSB selects the bank
    localparam int X_W      = 11;
    localparam int Y_W      = 11;
    localparam int DATA_W   = 8;
    localparam int CLIP_W   = 16;

    // Frame FSM encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DRAW      = 2'd1;
    localparam logic [1:0] ST_WAIT_SWAP = 2'd2;

    typedef struct packed {
        logic [DATA_W-1:0] colour;
        logic [X_W-1:0]    x;
        logic [Y_W-1:0]    y;
        logic              draw;
    } pix_beat_t;

    // True when the coordinate lies inside the visible area
    function automatic logic in_bounds(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
        return (32'(x) < 32'(H_RES)) && (32'(y) < 32'(V_RES));
    endfunction

endpackage

// File: rtl/framebuffer_writer_if.sv
// Pixel stream in, memory write port out, grouped as one bus.
interface framebuffer_writer_if;
    import fb_pkg::*;

    logic [DATA_W-1:0] in_data;
    logic [X_W-1:0]    in_x;
    logic [Y_W-1:0]    in_y;
    logic              in_draw;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              wr_ready;

    // Writer side: consumes pixels, issues memory writes
    modport slave (
        input  in_data, in_x, in_y, in_draw, in_valid, wr_ready,
        output in_ready, wr_addr, wr_data, wr_en
    );

    // Environment side: rasterizer plus memory
    modport master (
        output in_data, in_x, in_y, in_draw, in_valid, wr_ready,
        input  in_ready, wr_addr, wr_data, wr_en
    );

endinterface

// File: rtl/fb_addr_pipe.sv
// Two-stage clip/address pipeline: S1 clips and forms y*H_RES, S2 adds x
// and presents the memory write, holding it until the memory accepts.
module fb_addr_pipe
    import fb_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  pix_beat_t         in_beat,
    input  logic              in_valid,
    input  logic              accept_en,
    input  logic              back_bank,
    input  logic              wr_ready,
    output logic              in_ready,
    output logic              clip_hit,
    output logic              s1_valid,
    output logic              s2_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_en
);

    logic              s1_valid_q, s1_valid_d;
    logic              s1_draw_q,  s1_draw_d;
    logic [X_W-1:0]    s1_x_q,     s1_x_d;
    logic [DATA_W-1:0] s1_data_q,  s1_data_d;
    logic [ROW_W-1:0]  s1_row_q,   s1_row_d;

    logic              s2_valid_q, s2_valid_d;
    logic              s2_en_q,    s2_en_d;
    logic [ADDR_W-1:0] s2_addr_q,  s2_addr_d;
    logic [DATA_W-1:0] s2_data_q,  s2_data_d;

    logic s2_adv;
    logic accept;
    logic clipped;

    // Handshake and stage-advance decisions plus next-state for both stages
    always_comb begin
        // S2 only blocks while it holds a real write the memory has not taken
        s2_adv   = !s2_valid_q || !s2_en_q || wr_ready;
        in_ready = accept_en && (!s1_valid_q || s2_adv);
        accept   = in_valid && in_ready;
        clipped  = !in_bounds(in_beat.x, in_beat.y);
        clip_hit = accept && clipped;

        s1_valid_d = s1_valid_q;
        s1_draw_d  = s1_draw_q;
        s1_x_d     = s1_x_q;
        s1_data_d  = s1_data_q;
        s1_row_d   = s1_row_q;
        if (s2_adv) begin
            s1_valid_d = 1'b0;
        end
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_draw_d  = in_beat.draw && !clipped;
            s1_x_d     = in_beat.x;
            s1_data_d  = in_beat.colour;
            // Truncation only matters for clipped rows, which never write
            s1_row_d   = ROW_W'(in_beat.y) * ROW_W'(H_RES);
        end

        s2_valid_d = s2_valid_q;
        s2_en_d    = s2_en_q;
        s2_addr_d  = s2_addr_q;
        s2_data_d  = s2_data_q;
        if (s2_adv) begin
            s2_valid_d                = s1_valid_q;
            s2_en_d                   = s1_valid_q && s1_draw_q;
            s2_addr_d[BANK_BIT]       = back_bank;
            s2_addr_d[BANK_BIT-1:0]   = s1_row_q + ROW_W'(s1_x_q);
            s2_data_d                 = s1_data_q;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_draw_q  <= 1'b0;
            s1_x_q     <= '0;
            s1_data_q  <= '0;
            s1_row_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_en_q    <= 1'b0;
            s2_addr_q  <= '0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_draw_q  <= s1_draw_d;
            s1_x_q     <= s1_x_d;
            s1_data_q  <= s1_data_d;
            s1_row_q   <= s1_row_d;
            s2_valid_q <= s2_valid_d;
            s2_en_q    <= s2_en_d;
            s2_addr_q  <= s2_addr_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign s1_valid = s1_valid_q;
    assign s2_valid = s2_valid_q;
    assign wr_en    = s2_valid_q && s2_en_q;
    assign wr_addr  = s2_addr_q;
    assign wr_data  = s2_data_q;

endmodule

// File: rtl/framebuffer_writer.sv
// Frame-level control: draws into the back bank, swaps banks on the vsync
// following end of frame, and counts clipped beats.
module framebuffer_writer
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    framebuffer_writer_if.slave bus,
    input  logic               frame_start,
    input  logic               frame_done,
    input  logic               vsync,
    output logic               front_buf,
    output logic               frame_swapped,
    output logic               busy,
    output logic [CLIP_W-1:0]  clip_count
);

    logic [1:0]        state_q,   state_d;
    logic              front_q,   front_d;
    logic              back_q,    back_d;
    logic              done_q,    done_d;
    logic              fd_prev_q, fd_prev_d;
    logic              swapped_q, swapped_d;
    logic [CLIP_W-1:0] clip_q,    clip_d;

    pix_beat_t in_beat;
    logic      clip_hit;
    logic      s1_valid;
    logic      s2_valid;
    logic      fd_rise;

    assign in_beat = '{colour: bus.in_data, x: bus.in_x, y: bus.in_y, draw: bus.in_draw};

    fb_addr_pipe u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_beat   (in_beat),
        .in_valid  (bus.in_valid),
        .accept_en (state_q == ST_DRAW),
        .back_bank (back_q),
        .wr_ready  (bus.wr_ready),
        .in_ready  (bus.in_ready),
        .clip_hit  (clip_hit),
        .s1_valid  (s1_valid),
        .s2_valid  (s2_valid),
        .wr_addr   (bus.wr_addr),
        .wr_data   (bus.wr_data),
        .wr_en     (bus.wr_en)
    );

    // Frame FSM, bank bookkeeping and clip counter next-state
    always_comb begin
        // A level already high when it was last sampled is not an edge
        fd_rise   = frame_done && !fd_prev_q;
        fd_prev_d = frame_done;
        state_d   = state_q;
        front_d   = front_q;
        back_d    = back_q;
        done_d    = done_q;
        swapped_d = 1'b0;
        clip_d    = clip_q;

        if (clip_hit && (clip_q != {CLIP_W{1'b1}})) begin
            clip_d = clip_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d = ST_DRAW;
                    back_d  = ~front_q;
                    done_d  = 1'b0;
                    clip_d  = '0;
                end
            end
            ST_DRAW: begin
                if (fd_rise) begin
                    done_d = 1'b1;
                end
                // Beats still in flight must reach memory before the swap
                if (done_q && !s1_valid && !s2_valid) begin
                    state_d = ST_WAIT_SWAP;
                end
            end
            ST_WAIT_SWAP: begin
                if (vsync) begin
                    front_d   = ~front_q;
                    swapped_d = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Frame control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            front_q   <= 1'b0;
            back_q    <= 1'b1;
            done_q    <= 1'b0;
            fd_prev_q <= 1'b0;
            swapped_q <= 1'b0;
            clip_q    <= '0;
        end else begin
            state_q   <= state_d;
            front_q   <= front_d;
            back_q    <= back_d;
            done_q    <= done_d;
            fd_prev_q <= fd_prev_d;
            swapped_q <= swapped_d;
            clip_q    <= clip_d;
        end
    end

    assign front_buf     = front_q;
    assign frame_swapped = swapped_q;
    assign busy          = (state_q != ST_IDLE);
    assign clip_count    = clip_q;

endmodule

// File: tb/tb_framebuffer_writer.sv
// Scoreboard bench for framebuffer_writer: expected writes are queued when a
// beat is accepted and compared when the memory port takes the write.
module tb_framebuffer_writer;
    import fb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        frame_done = 1'b0;
    logic        vsync = 1'b0;
    logic        front_buf;
    logic        frame_swapped;
    logic        busy;
    logic [15:0] clip_count;

    framebuffer_writer_if bus();

    framebuffer_writer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus.slave),
        .frame_start   (frame_start),
        .frame_done    (frame_done),
        .vsync         (vsync),
        .front_buf     (front_buf),
        .frame_swapped (frame_swapped),
        .busy          (busy),
        .clip_count    (clip_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [27:0] exp_q[$];
    logic        back_model = 1'b1;
    int          wcount = 0;
    int          run_len = 0;
    int          last_wr_cyc = -10;
    int          cyc = 0;
    logic [19:0] last_wr_addr = '0;
    bit          prev_stall = 1'b0;
    logic [19:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    bit          skip_stab = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory-side monitor: pops the scoreboard on every accepted write and
    // checks that a stalled write holds still.
    always begin
        @(negedge clk);
        #2;
        cyc++;
        if (prev_stall && !skip_stab) begin
            check("hold_en",   32'(bus.wr_en),   32'd1);
            check("hold_addr", 32'(bus.wr_addr), 32'(prev_addr));
            check("hold_data", 32'(bus.wr_data), 32'(prev_data));
        end
        if (bus.wr_en && bus.wr_ready) begin
            $display("write addr=0x%05h data=0x%02h", bus.wr_addr, bus.wr_data);
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(bus.wr_en), 32'd0);
            end else begin
                logic [27:0] e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(bus.wr_addr), 32'(e[27:8]));
                check("wr_data", 32'(bus.wr_data), 32'(e[7:0]));
            end
            wcount++;
            run_len      = (last_wr_cyc == cyc - 1) ? run_len + 1 : 1;
            last_wr_cyc  = cyc;
            last_wr_addr = bus.wr_addr;
        end
        prev_stall = rst_n && bus.wr_en && !bus.wr_ready;
        prev_addr  = bus.wr_addr;
        prev_data  = bus.wr_data;
    end

    // Called at a falling edge; returns at the falling edge after acceptance
    task automatic send(input int x, input int y, input logic [7:0] c, input logic d);
        int tries = 0;
        bit done = 1'b0;
        bus.in_x     = 11'(x);
        bus.in_y     = 11'(y);
        bus.in_data  = c;
        bus.in_draw  = d;
        bus.in_valid = 1'b1;
        while (!done) begin
            #1;
            if (bus.in_ready) begin
                if (d && x < 800 && y < 600) begin
                    exp_q.push_back({back_model, 19'(y * 800 + x), c});
                end
                done = 1'b1;
            end else if (tries >= 60) begin
                check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
                done = 1'b1;
            end
            @(negedge clk);
            tries++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        int n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
        end
        @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.in_data  = '0;
        bus.in_draw  = 1'b0;
        bus.wr_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_wr_en",    32'(bus.wr_en),    32'd0);
        check("rst_front",    32'(front_buf),    32'd0);
        check("rst_busy",     32'(busy),         32'd0);
        check("rst_clip",     32'(clip_count),   32'd0);
        check("rst_swapped",  32'(frame_swapped), 32'd0);
        @(negedge clk);

        // Single beat, two-cycle latency, bank 1
        back_model = 1'b1;
        pulse_start();
        #2;
        check("start_busy", 32'(busy), 32'd1);
        @(negedge clk);
        send(5, 2, 8'h3C, 1'b1);
        #2;
        check("lat_c1_en", 32'(bus.wr_en), 32'd0);
        @(negedge clk);
        #2;
        check("lat_c2_en",   32'(bus.wr_en),   32'd1);
        check("lat_c2_addr", 32'(bus.wr_addr), 32'h80645);
        check("lat_c2_data", 32'(bus.wr_data), 32'h3C);
        @(negedge clk);
        #2;
        check("lat_c3_en", 32'(bus.wr_en), 32'd0);
        @(negedge clk);

        // Ten back-to-back beats
        base = wcount;
        for (int i = 0; i < 10; i++) begin
            send(10 + i, 20 + i, 8'(i * 7 + 1), 1'b1);
        end
        wait_drain(40);
        check("burst_count", 32'(wcount - base), 32'd10);
        check("burst_run",   32'(run_len),       32'd10);

        // Memory stall for five cycles
        base = wcount;
        bus.wr_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    send(100 + i, 7, 8'(8'hA0 + i), 1'b1);
                end
            end
            begin
                repeat (4) @(negedge clk);
                #3;
                check("stall_in_ready", 32'(bus.in_ready), 32'd0);
                check("stall_wr_en",    32'(bus.wr_en),    32'd1);
                @(negedge clk);
                bus.wr_ready = 1'b1;
            end
        join
        wait_drain(40);
        check("stall_count", 32'(wcount - base), 32'd4);

        // Clipping and draw=0
        base = wcount;
        send(800, 0, 8'h01, 1'b1);
        send(0, 600, 8'h02, 1'b1);
        send(799, 599, 8'h55, 1'b0);
        repeat (3) @(negedge clk);
        #2;
        check("clip_count",  32'(clip_count),    32'd2);
        check("clip_nowrite", 32'(wcount - base), 32'd0);
        @(negedge clk);
        send(799, 599, 8'h77, 1'b1);
        wait_drain(20);
        check("corner_count", 32'(wcount - base), 32'd1);
        check("corner_low",   32'(last_wr_addr[18:0]), 32'd479999);

        // End of frame with beats in flight, edge coincident with an accept
        base = wcount;
        send(1, 0, 8'h11, 1'b1);
        frame_done = 1'b1;
        send(2, 0, 8'h22, 1'b1);
        wait_drain(20);
        repeat (2) @(negedge clk);
        #2;
        check("eof_count",    32'(wcount - base), 32'd2);
        check("eof_busy",     32'(busy),          32'd1);
        check("eof_in_ready", 32'(bus.in_ready),  32'd0);
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        #2;
        check("swap_front",   32'(front_buf),     32'd1);
        check("swap_pulse",   32'(frame_swapped), 32'd1);
        check("swap_busy",    32'(busy),          32'd0);
        @(negedge clk);
        #2;
        check("swap_pulse_end", 32'(frame_swapped), 32'd0);
        @(negedge clk);

        // Asynchronous reset while a write is stalled
        back_model = 1'b0;
        pulse_start();
        bus.wr_ready = 1'b0;
        send(3, 4, 8'h99, 1'b1);
        @(negedge clk);
        #2;
        check("rstmid_pre_en",   32'(bus.wr_en),   32'd1);
        check("rstmid_pre_addr", 32'(bus.wr_addr), 32'(3203));
        skip_stab = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        check("rstmid_wr_en",    32'(bus.wr_en),    32'd0);
        check("rstmid_front",    32'(front_buf),    32'd0);
        check("rstmid_busy",     32'(busy),         32'd0);
        check("rstmid_in_ready", 32'(bus.in_ready), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        bus.wr_ready = 1'b1;
        @(negedge clk);
        skip_stab = 1'b0;
        repeat (2) @(negedge clk);

        // frame_done already high when the frame starts is not an end of frame
        back_model = 1'b1;
        pulse_start();
        send(1, 1, 8'h42, 1'b1);
        wait_drain(20);
        repeat (3) @(negedge clk);
        #2;
        check("lvl_in_ready", 32'(bus.in_ready), 32'd1);
        check("lvl_busy",     32'(busy),         32'd1);
        @(negedge clk);
        frame_done = 1'b0;
        repeat (2) @(negedge clk);
        #2;
        check("lvl_low_in_ready", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        frame_done = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("lvl_rise_in_ready", 32'(bus.in_ready), 32'd0);
        check("lvl_rise_busy",     32'(busy),         32'd1);
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        vsync = 1'b0;
        #2;
        check("lvl_swap_front", 32'(front_buf),     32'd1);
        check("lvl_swap_pulse", 32'(frame_swapped), 32'd1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
